// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Groups the bus signals around the data-memory arbiter. These are the
//   core load/store path, the loader (debug/DMA) port and the memory port.
//   slave  : arbiter side (consumes requests and mem_rdata, drives grants/mem_*)
//   master : environment side (core, loader and memory model)
//   Parameters: ADDR_W (byte address width), DATA_W (data width).
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
);
    // core side
    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic [DATA_W-1:0] core_rdata;
    logic              core_stall;
    // loader side
    logic              ld_req;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_gnt;
    logic              ld_rvalid;
    logic [DATA_W-1:0] ld_rdata;
    // memory side
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        input  ld_req, ld_we, ld_addr, ld_wdata,
        input  mem_rdata,
        output core_rdata, core_stall,
        output ld_gnt, ld_rvalid, ld_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        output ld_req, ld_we, ld_addr, ld_wdata,
        output mem_rdata,
        input  core_rdata, core_stall,
        input  ld_gnt, ld_rvalid, ld_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single synchronous data-memory port between the RV32I core
//   load/store path and a program/data loader. The core is stalled while the
//   port is busy or a load is in flight. Loader bursts are bounded to
//   MAX_BURST grants while the core waits, so the core cannot starve.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   bus            dmem_arbiter_if.slave. Carries the core request/stall/rdata,
//                  the loader req/gnt/rvalid/rdata and the memory port (mem_*, busy).
//   perf_stall_cnt (only with DMEM_ARB_PERF_EN) counts core stall cycles
//                  caused by loader contention. Wraps at 2^32.
//
// Parameters
//   ADDR_W (10), DATA_W (32), MAX_BURST (8, legal 1..255)
//
// Optional feature macro: DMEM_ARB_PERF_EN
module dmem_arbiter #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]   perf_stall_cnt
`endif
);

    localparam logic [7:0] MAX_B = 8'(MAX_BURST);

    logic              rd_pend_core;
    logic              rd_pend_ld;
    logic [7:0]        burst_cnt;

    logic              core_elig;
    logic              ld_prio;
    logic              core_gnt;
    logic              ld_win;
    logic              mux_we;
    logic [ADDR_W-1:0] mux_addr;
    logic [DATA_W-1:0] mux_wdata;

    // Arbitration. Every grant is gated by reset so that all outputs read 0
    // while reset is held low, including the combinational ones.
    always_comb begin
        core_elig = bus.core_req && !rd_pend_core;
        ld_prio   = bus.ld_req && (burst_cnt != 8'd0) && (burst_cnt < MAX_B);
        core_gnt  = reset && core_elig && !ld_prio;
        ld_win    = reset && bus.ld_req && !core_gnt;
    end

    // Memory port mux. Idle cycles drive zeros.
    always_comb begin
        mux_we    = 1'b0;
        mux_addr  = '0;
        mux_wdata = '0;
        if (core_gnt) begin
            mux_we    = bus.core_we;
            mux_addr  = bus.core_addr;
            mux_wdata = bus.core_wdata;
        end else if (ld_win) begin
            mux_we    = bus.ld_we;
            mux_addr  = bus.ld_addr;
            mux_wdata = bus.ld_wdata;
        end
    end

    always_comb begin
        bus.mem_en    = core_gnt || ld_win;
        bus.busy      = core_gnt || ld_win;
        bus.mem_we    = mux_we;
        bus.mem_addr  = mux_addr;
        bus.mem_wdata = mux_wdata;
        bus.ld_gnt    = ld_win;
    end

    // Core handshake. A granted store completes in its grant cycle. A granted
    // load stalls once and completes in the following cycle. In that
    // completion cycle core_req is ignored and stall is released.
    always_comb begin
        bus.core_stall = 1'b0;
        if (reset && bus.core_req && !rd_pend_core)
            bus.core_stall = !(core_gnt && bus.core_we);
        bus.core_rdata = rd_pend_core ? bus.mem_rdata : '0;
    end

    always_comb begin
        bus.ld_rvalid = rd_pend_ld;
        bus.ld_rdata  = rd_pend_ld ? bus.mem_rdata : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_pend_core <= 1'b0;
            rd_pend_ld   <= 1'b0;
            burst_cnt    <= 8'd0;
        end else begin
            rd_pend_core <= core_gnt && !bus.core_we;
            rd_pend_ld   <= ld_win && !bus.ld_we;
            // A grant taken at the cap restarts the count at 1, so an
            // uncontended loader keeps streaming. Any gap clears the count.
            if (ld_win)
                burst_cnt <= (burst_cnt >= MAX_B) ? 8'd1 : burst_cnt + 8'd1;
            else
                burst_cnt <= 8'd0;
        end
    end

`ifdef DMEM_ARB_PERF_EN
    // Contention stalls only: the core was eligible but the loader held
    // priority. Stalls from load latency are not counted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            perf_stall_cnt <= '0;
        else if (core_elig && ld_prio)
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned MAX_BURST = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_stall_cnt;
`endif

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef DMEM_ARB_PERF_EN
        ,
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    // synchronous memory model, 1-cycle read latency
    logic [31:0] mem [0:255];
    initial begin
        for (int k = 0; k < 256; k++) mem[k] = 32'hA5A5_0000 | k;
        bus.mem_rdata = 32'h5A5A_5A5A;
    end
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
            else            bus.mem_rdata <= mem[bus.mem_addr[9:2]];
        end
    end

    logic [31:0] shadow [0:255];
    logic [31:0] core_q [$];
    logic [31:0] ld_q [$];
    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_d;

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        bus.core_req = 1'b0; bus.core_we = 1'b0; bus.core_addr = '0; bus.core_wdata = '0;
        bus.ld_req = 1'b0; bus.ld_we = 1'b0; bus.ld_addr = '0; bus.ld_wdata = '0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0;
        bus.core_req = 1'b1; bus.core_addr = 10'h3FC; bus.core_wdata = 32'hFFFF_FFFF;
        bus.ld_req = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = 10'h3F0; bus.ld_wdata = 32'h1111_1111;
        repeat (2) @(negedge clk);
        #2;
        n_vec++;
        if ({bus.core_stall, bus.ld_gnt, bus.ld_rvalid, bus.mem_en, bus.mem_we, bus.busy} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctl got %b want 000000",
                     {bus.core_stall, bus.ld_gnt, bus.ld_rvalid, bus.mem_en, bus.mem_we, bus.busy});
        end
        n_vec++;
        if ({bus.core_rdata, bus.ld_rdata} !== 64'h0) begin
            n_err++;
            $display("FAIL reset_rdata got %h want 0", {bus.core_rdata, bus.ld_rdata});
        end
        n_vec++;
        if ({bus.mem_addr, bus.mem_wdata} !== 42'h0) begin
            n_err++;
            $display("FAIL reset_mem got %h want 0", {bus.mem_addr, bus.mem_wdata});
        end
        @(negedge clk);
        idle();
        reset = 1'b1;
        #2;
        n_vec++;
        if ({bus.core_stall, bus.ld_gnt, bus.ld_rvalid, bus.mem_en} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_release got %b want 0000",
                     {bus.core_stall, bus.ld_gnt, bus.ld_rvalid, bus.mem_en});
        end
    endtask

    task automatic test_core_store();
        @(negedge clk);
        idle();
        bus.core_req = 1'b1; bus.core_we = 1'b1; bus.core_addr = 10'h010; bus.core_wdata = 32'hDEAD_BEEF;
        shadow[4] = 32'hDEAD_BEEF;
        #2;
        n_vec++;
        if ({bus.mem_en, bus.mem_we, bus.core_stall, bus.ld_gnt} !== 4'b1100) begin
            n_err++;
            $display("FAIL store_ctl got %b want 1100", {bus.mem_en, bus.mem_we, bus.core_stall, bus.ld_gnt});
        end
        n_vec++;
        if (bus.mem_addr !== 10'h010 || bus.mem_wdata !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL store_bus got %h/%h want 010/deadbeef", bus.mem_addr, bus.mem_wdata);
        end
    endtask

    task automatic test_core_load();
        @(negedge clk);
        idle();
        bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 10'h010;
        core_q.push_back(shadow[4]);
        #2;
        n_vec++;
        if ({bus.mem_en, bus.mem_we, bus.core_stall} !== 3'b101 || bus.mem_addr !== 10'h010) begin
            n_err++;
            $display("FAIL load_grant got %b addr %h want 101 addr 010",
                     {bus.mem_en, bus.mem_we, bus.core_stall}, bus.mem_addr);
        end
        @(negedge clk);
        #2;
        n_vec++;
        if ({bus.core_stall, bus.mem_en} !== 2'b00) begin
            n_err++;
            $display("FAIL load_complete got %b want 00", {bus.core_stall, bus.mem_en});
        end
        exp_d = core_q.pop_front();
        n_vec++;
        if (bus.core_rdata !== exp_d) begin
            n_err++;
            $display("FAIL load_rdata got %h want %h", bus.core_rdata, exp_d);
        end
    endtask

    task automatic test_loader_burst();
        int wi = 0;
        int ld_before = 0;
        int core_gnt_cyc = -1;
        int core_done_cyc = -1;
        int last_ld_cyc = -1;
        bit core_done = 1'b0;
        bit finished = 1'b0;
`ifdef DMEM_ARB_PERF_EN
        logic [31:0] p0;
`endif
        @(negedge clk);
        idle();
`ifdef DMEM_ARB_PERF_EN
        p0 = perf_stall_cnt;
`endif
        for (int cyc = 0; cyc < 60 && !finished; cyc++) begin
            @(negedge clk);
            if (wi < 20) begin
                bus.ld_req = 1'b1; bus.ld_we = 1'b1;
                bus.ld_addr = 10'(10'h100 + 4 * wi); bus.ld_wdata = 32'hC0DE_0000 + 32'(wi);
            end else begin
                bus.ld_req = 1'b0;
            end
            if (cyc >= 1 && !core_done) begin
                if (cyc == 1) core_q.push_back(shadow[4]);
                bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 10'h010;
            end else begin
                bus.core_req = 1'b0;
            end
            #2;
            if (bus.core_req && !bus.core_stall) begin
                exp_d = core_q.pop_front();
                n_vec++;
                if (bus.core_rdata !== exp_d) begin
                    n_err++;
                    $display("FAIL burst_core_rdata got %h want %h", bus.core_rdata, exp_d);
                end
                core_done = 1'b1;
                core_done_cyc = cyc;
                n_vec++;
                if (bus.ld_gnt !== 1'b1) begin
                    n_err++;
                    $display("FAIL burst_resume ld_gnt got %b want 1", bus.ld_gnt);
                end
            end
            if (bus.core_req && bus.mem_en && !bus.ld_gnt && core_gnt_cyc < 0) begin
                core_gnt_cyc = cyc;
                n_vec++;
                if ({bus.mem_we, bus.core_stall} !== 2'b01 || bus.mem_addr !== 10'h010) begin
                    n_err++;
                    $display("FAIL burst_core_grant got %b addr %h want 01 addr 010",
                             {bus.mem_we, bus.core_stall}, bus.mem_addr);
                end
            end
            if (bus.ld_gnt) begin
                shadow[bus.ld_addr[9:2]] = bus.ld_wdata;
                wi++;
                last_ld_cyc = cyc;
                if (core_gnt_cyc < 0) ld_before++;
            end
            if (wi == 20 && core_done) finished = 1'b1;
        end
        n_vec++;
        if (!finished) begin
            n_err++;
            $display("FAIL burst_timeout got words %0d core_done %0d want 20 1", wi, core_done);
        end
        n_vec++;
        if (ld_before !== MAX_BURST) begin
            n_err++;
            $display("FAIL burst_len got %0d want %0d", ld_before, MAX_BURST);
        end
        n_vec++;
        if (core_gnt_cyc !== 8 || core_done_cyc !== 9) begin
            n_err++;
            $display("FAIL burst_core_cycles got %0d/%0d want 8/9", core_gnt_cyc, core_done_cyc);
        end
        n_vec++;
        if (last_ld_cyc !== 20) begin
            n_err++;
            $display("FAIL burst_last_write got cycle %0d want 20", last_ld_cyc);
        end
`ifdef DMEM_ARB_PERF_EN
        n_vec++;
        if (perf_stall_cnt - p0 !== 32'd7) begin
            n_err++;
            $display("FAIL perf_stall got %0d want 7", perf_stall_cnt - p0);
        end
`endif
    endtask

    task automatic test_loader_readback();
        int ri = 0;
        int nr = 0;
        @(negedge clk);
        idle();
        for (int cyc = 0; cyc < 40 && nr < 20; cyc++) begin
            @(negedge clk);
            if (ri < 20) begin
                bus.ld_req = 1'b1; bus.ld_we = 1'b0; bus.ld_addr = 10'(10'h100 + 4 * ri);
            end else begin
                bus.ld_req = 1'b0;
            end
            #2;
            if (bus.ld_rvalid) begin
                n_vec++;
                if (ld_q.size() == 0) begin
                    n_err++;
                    $display("FAIL readback_spurious got rvalid 1 want 0");
                end else begin
                    exp_d = ld_q.pop_front();
                    if (bus.ld_rdata !== exp_d) begin
                        n_err++;
                        $display("FAIL readback_data got %h want %h", bus.ld_rdata, exp_d);
                    end
                end
                nr++;
            end
            if (bus.ld_gnt) begin
                ld_q.push_back(shadow[bus.ld_addr[9:2]]);
                ri++;
            end
        end
        n_vec++;
        if (nr !== 20 || ld_q.size() != 0) begin
            n_err++;
            $display("FAIL readback_count got %0d left %0d want 20 left 0", nr, ld_q.size());
        end
    endtask

    task automatic test_loader_read();
        @(negedge clk);
        idle();
        bus.ld_req = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = 10'h020; bus.ld_wdata = 32'h1234_5678;
        shadow[8] = 32'h1234_5678;
        #2;
        n_vec++;
        if ({bus.ld_gnt, bus.mem_we} !== 2'b11) begin
            n_err++;
            $display("FAIL ldwr_grant got %b want 11", {bus.ld_gnt, bus.mem_we});
        end
        @(negedge clk);
        bus.ld_we = 1'b0;
        ld_q.push_back(shadow[8]);
        #2;
        n_vec++;
        if ({bus.ld_gnt, bus.ld_rvalid, bus.mem_we} !== 3'b100) begin
            n_err++;
            $display("FAIL ldrd_grant got %b want 100", {bus.ld_gnt, bus.ld_rvalid, bus.mem_we});
        end
        @(negedge clk);
        idle();
        #2;
        exp_d = ld_q.pop_front();
        n_vec++;
        if (bus.ld_rvalid !== 1'b1 || bus.ld_rdata !== exp_d) begin
            n_err++;
            $display("FAIL ldrd_data got %b/%h want 1/%h", bus.ld_rvalid, bus.ld_rdata, exp_d);
        end
        @(negedge clk);
        #2;
        n_vec++;
        if (bus.ld_rvalid !== 1'b0 || bus.ld_rdata !== 32'h0) begin
            n_err++;
            $display("FAIL ldrd_after got %b/%h want 0/0", bus.ld_rvalid, bus.ld_rdata);
        end
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        idle();
        bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 10'h020;
        bus.ld_req = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = 10'h030; bus.ld_wdata = 32'h0BAD_F00D;
        core_q.push_back(shadow[8]);
        #2;
        n_vec++;
        if ({bus.ld_gnt, bus.core_stall} !== 2'b01 || bus.mem_addr !== 10'h020) begin
            n_err++;
            $display("FAIL simul_grant got %b addr %h want 01 addr 020", {bus.ld_gnt, bus.core_stall}, bus.mem_addr);
        end
        @(negedge clk);
        #2;
        exp_d = core_q.pop_front();
        n_vec++;
        if (bus.core_stall !== 1'b0 || bus.core_rdata !== exp_d) begin
            n_err++;
            $display("FAIL simul_complete got %b/%h want 0/%h", bus.core_stall, bus.core_rdata, exp_d);
        end
        n_vec++;
        if ({bus.ld_gnt, bus.mem_we} !== 2'b11 || bus.mem_addr !== 10'h030) begin
            n_err++;
            $display("FAIL simul_loader got %b addr %h want 11 addr 030", {bus.ld_gnt, bus.mem_we}, bus.mem_addr);
        end
        shadow[12] = 32'h0BAD_F00D;
    endtask

    task automatic test_burst_drop();
        logic [3:0] got;
        logic [3:0] want [0:6];
        // {ld_gnt, core_stall, mem_en, mem_we}
        want[0] = 4'b1011; want[1] = 4'b1011; want[2] = 4'b1011;
        want[3] = 4'b1111; want[4] = 4'b0011; want[5] = 4'b0011; want[6] = 4'b1011;
        @(negedge clk);
        idle();
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            idle();
            bus.ld_req = (c != 4); bus.ld_we = 1'b1;
            bus.ld_addr = 10'h040; bus.ld_wdata = 32'h7700_0000 + 32'(c);
            if (c >= 3 && c <= 5) begin
                bus.core_req = 1'b1; bus.core_we = 1'b1;
                bus.core_addr = (c == 5) ? 10'h054 : 10'h050; bus.core_wdata = 32'h6600_0000 + 32'(c);
            end
            #2;
            got = {bus.ld_gnt, bus.core_stall, bus.mem_en, bus.mem_we};
            n_vec++;
            if (got !== want[c]) begin
                n_err++;
                $display("FAIL burst_drop_c%0d got %b want %b", c, got, want[c]);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        logic [4:0] got;
        @(negedge clk);
        idle();
        bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 10'h010;
        #2;
        n_vec++;
        if (bus.core_stall !== 1'b1) begin
            n_err++;
            $display("FAIL rstrd_grant got stall %b want 1", bus.core_stall);
        end
        @(negedge clk);
        reset = 1'b0;
        #2;
        got = {bus.core_stall, bus.mem_en, bus.ld_gnt, bus.ld_rvalid, bus.busy};
        n_vec++;
        if (got !== 5'b0 || bus.core_rdata !== 32'h0) begin
            n_err++;
            $display("FAIL rstrd_core got %b/%h want 00000/0", got, bus.core_rdata);
        end
        @(negedge clk);
        idle();
        reset = 1'b1;
        bus.ld_req = 1'b1; bus.ld_we = 1'b0; bus.ld_addr = 10'h020;
        #2;
        n_vec++;
        if ({bus.ld_gnt, bus.core_stall} !== 2'b10) begin
            n_err++;
            $display("FAIL rstrd_ldgrant got %b want 10", {bus.ld_gnt, bus.core_stall});
        end
        @(negedge clk);
        reset = 1'b0;
        #2;
        n_vec++;
        if (bus.ld_rvalid !== 1'b0 || bus.ld_rdata !== 32'h0) begin
            n_err++;
            $display("FAIL rstrd_ld got %b/%h want 0/0", bus.ld_rvalid, bus.ld_rdata);
        end
        @(negedge clk);
        idle();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #2;
            got = {bus.core_stall, bus.mem_en, bus.ld_gnt, bus.ld_rvalid, bus.busy};
            n_vec++;
            if (got !== 5'b0 || bus.core_rdata !== 32'h0) begin
                n_err++;
                $display("FAIL rstrd_after_c%0d got %b/%h want 00000/0", c, got, bus.core_rdata);
            end
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_core_store();
        test_core_load();
        test_loader_burst();
        test_loader_readback();
        test_loader_read();
        test_simultaneous();
        test_burst_drop();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single synchronous data-memory port between the RV32I core's load/store path and a program/data loader (debug or DMA master). Sits between the core's ALU-result/store-data path and the data memory. Stalls the core when the port is busy. Bounds loader bursts so the core cannot starve.

Parameters:
ADDR_W, 10, byte address width of the memory port (matches PC/memory sizing)
DATA_W, 32, data width
MAX_BURST, 8, maximum consecutive loader grants while the core is waiting; legal range 1..255

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
core_req  input  1  core memory access request (MemRead|MemWrite), held until core_stall is low
core_we  input  1  1 = store, 0 = load
core_addr  input  ADDR_W  core address
core_wdata  input  DATA_W  core store data
core_rdata  output  DATA_W  load data to core, valid when core_stall=0 in the completion cycle
core_stall  output  1  freeze PC and register file this cycle
ld_req  input  1  loader request
ld_we  input  1  loader write enable
ld_addr  input  ADDR_W  loader address
ld_wdata  input  DATA_W  loader write data
ld_gnt  output  1  loader request accepted this cycle (combinational)
ld_rvalid  output  1  loader read data valid (cycle after a read grant)
ld_rdata  output  DATA_W  loader read data
mem_en  output  1  memory access strobe
mem_we  output  1  memory write strobe
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, valid 1 cycle after mem_en with mem_we=0
busy  output  1  equals mem_en

Behaviour:
- Memory model: synchronous, 1-cycle read latency; writes commit on the edge ending the grant cycle.
- Registered state: rd_pend_core, rd_pend_ld, burst_cnt (8-bit). All clear on reset=0, asynchronously.
- Reset values: all outputs 0, except core_rdata, ld_rdata, mem_addr and mem_wdata, which are 0 while reset is low.
- Core is eligible when core_req=1 and rd_pend_core=0. In the completion cycle of a core load, core_req is ignored.
- Loader priority: when 1 <= burst_cnt < MAX_BURST and ld_req=1, the loader wins. Otherwise the core wins. The loader is granted whenever it is not beaten by the core.
- At most one grant per cycle. The mux drives mem_* from the winner. Idle cycles: mem_en=0, mem_we=0.
- Core write granted: mem_we=1, core_stall=0 (single-cycle completion).
- Core read granted: core_stall=1, and rd_pend_core is set next cycle.
- rd_pend_core=1: core_rdata=mem_rdata, core_stall=0, rd_pend_core clears. The port is free for the loader in this cycle.
- core_req=1, not eligible for completion, and not granted: core_stall=1.
- core_req=0: core_stall=0.
- Loader read grant: ld_rvalid=1 and ld_rdata=mem_rdata next cycle. Otherwise ld_rvalid=0 and ld_rdata=0.
- burst_cnt: increments on each loader grant. Saturates by restarting at 1 when a grant occurs at MAX_BURST. Clears to 0 on any cycle without a loader grant.
- Simultaneous fresh core_req and ld_req with burst_cnt=0: the core wins.
- ld_req dropping mid-burst: burst_cnt clears next cycle.
- Reset mid-read: pending data is dropped, and no rvalid or completion occurs after reset.

Optional Feature:
DMEM_ARB_PERF_EN:
- With the macro defined: adds output perf_stall_cnt (32-bit), counting cycles where core_stall=1 caused by loader contention (not read latency). Wraps at 2^32, clears on reset.
- Without the macro: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- Core store alone, addr 0x010, data 0xDEADBEEF -> same cycle mem_en=1, mem_we=1, core_stall=0; no stall.
- Core load of 0x010 after the store -> cycle N: core_stall=1, mem_en=1, mem_we=0; cycle N+1: core_stall=0, core_rdata=0xDEADBEEF.
- Loader writes 20 consecutive words (ld_req held) while core_req is held as a load, MAX_BURST=8 -> loader granted 8 cycles, core granted 1 cycle, core completes next cycle while the loader resumes; no lost writes.
- Simultaneous fresh core_req and ld_req, burst_cnt=0 -> core granted, ld_gnt=0; loader granted in the core's completion cycle.
- Loader read of 0x020 after writing 0x12345678 -> ld_gnt cycle N; ld_rvalid=1, ld_rdata=0x12345678 at N+1.
- reset driven low during a pending core read -> all outputs 0 immediately; after release, core_stall=0 and ld_rvalid=0 until new requests arrive.
